spi_master_multi: RTL and testbench
===================================

SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

Interface
REQ-001 Parameter: DATA_W, 32, maximum transfer length in bits (8..32).
REQ-002 Parameter: NCS, 4, number of chip-select lines (1..8).
REQ-003 Parameter: DIV_W, 16, width of the runtime divider register.
REQ-004 Parameter: DIV_COEF, 1, divider reset value; SCK half-period = (div+1) clk_in cycles.
REQ-005 Parameter: TURN_BITS, 8, bits driven before bus turnaround in 3-wire read.
REQ-006 Port: clk_in  in  1  sole clock, all logic on rising edge.
REQ-007 Port: reset  in  1  asynchronous, active-high reset.
REQ-008 Port: request  in  1  single-cycle transfer request.
REQ-009 Port: nbits  in  clog2(DATA_W)  transfer length minus one; 0 = divider load.
REQ-010 Port: mosi_data  in  DATA_W  transmit word, bit nbits sent first.
REQ-011 Port: cs_sel  in  clog2(NCS)  chip-select index.
REQ-012 Port: cpol, cpha  in  1 each  SPI mode, sampled at request.
REQ-013 Port: spi3w  in  1  3-wire mode, sampled at request.
REQ-014 Port: ready  out  1  high only in IDLE.
REQ-015 Port: miso_data  out  DATA_W  received word, right-justified.
REQ-016 Port: miso_valid  out  1  one-cycle pulse, miso_data updated.
REQ-017 Port: spi_csn  out  NCS  active-low chip selects.
REQ-018 Port: spi_sck, spi_mosi, spi_mosi_oe  out  1 each  clock, data out, data-out enable.
REQ-019 Port: spi_miso, spi_mosi_i  in  1 each  4-wire input, 3-wire pad readback.

Function
REQ-020 States SHALL be IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE; each non-IDLE phase except SHIFT lasts one SCK half-period.
REQ-021 request SHALL be accepted only when ready=1; requests while ready=0 SHALL be ignored, with no queueing.
REQ-022 On accepted request with nbits=0: divider <= mosi_data[DIV_W-1:0] at next edge; no SPI activity; ready stays 1.
REQ-023 On accepted request with nbits>0: mosi_data, nbits, cs_sel, cpol, cpha, spi3w latched; ready=0 and spi_csn[cs_sel]=0 on next cycle (SETUP).
REQ-024 cs_sel >= NCS: transfer runs with all spi_csn high.
REQ-025 SCK SHALL idle at latched cpol, produce exactly nbits+1 pulses, half-period (div+1) cycles.
REQ-026 cpha=0: MOSI valid from SETUP, sample on leading edge, shift on trailing edge; cpha=1: shift on leading, sample on trailing.
REQ-027 Bits SHALL be sent MSB-first from mosi_data[nbits] down to [0]; spi_mosi=0 outside SHIFT/SETUP.
REQ-028 Received bits SHALL assemble into miso_data[nbits:0], upper bits 0.
REQ-029 Sampled input: spi_miso in 4-wire; spi_mosi_i in 3-wire.
REQ-030 spi_mosi_oe SHALL be 1 except in a 3-wire read (mosi_data[nbits]=1, nbits+1 > TURN_BITS), where it drops after TURN_BITS bits driven until GAP.
REQ-031 At GAP->IDLE: miso_valid=1 for one cycle, coincident with ready rising; spi_csn all high throughout GAP.
REQ-032 Divider value changes SHALL NOT affect a transfer in progress (divider load only in IDLE).
REQ-033 Maximum length nbits=DATA_W-1 SHALL transfer DATA_W bits with no counter wrap.

Reset
REQ-034 reset=1 SHALL asynchronously force IDLE, spi_csn all 1, spi_sck 0, spi_mosi 0, spi_mosi_oe 1, ready 1, miso_valid 0, miso_data 0, divider DIV_COEF.
REQ-035 reset mid-transfer SHALL abort immediately; no miso_valid pulse results.

Verification
REQ-036 div=1 default, cs_sel=0, mode 0, nbits=15, mosi_data=0x8f00, slave returns 0x33 -> 16 SCK pulses, period 4 clk, csn[0] low only, miso_data=0x00000033, one miso_valid.
REQ-037 request nbits=0 mosi_data=3, then nbits=7 mosi_data=0xA5 -> no csn activity on load; then SCK period 8 clk, MOSI 1010_0101.
REQ-038 cpol=1 cpha=1 cs_sel=2, nbits=7, 0x5A -> SCK idles 1, csn[2] only low, data changes on falling, sampled on rising.
REQ-039 spi3w=1, nbits=15, 0x8f00, pad returns 0x33 -> oe=0 after 8th bit until GAP, miso_data=0x0033.
REQ-040 reset pulse at 5th SCK pulse, plus request while busy -> csn all high same cycle, ready=1, no miso_valid, busy request ignored.

Source files
------------

// File: rtl/spi_master_multi.sv
// Multi-mode SPI master: 3/4-wire, CPOL/CPHA, runtime SCK divider, up to NCS chip selects.
// Latency: SETUP + 2*(nbits+1) SCK half-periods + HOLD + GAP; miso_valid pulses as ready rises.
// Backpressure: request is taken only while ready=1; requests while busy are dropped, never queued.
module spi_master_multi #(
    parameter int DATA_W    = 32,
    parameter int NCS       = 4,
    parameter int DIV_W     = 16,
    parameter int DIV_COEF  = 1,
    parameter int TURN_BITS = 8,
    localparam int NB_W     = $clog2(DATA_W),
    localparam int CS_W     = (NCS > 1) ? $clog2(NCS) : 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              request,
    input  logic [NB_W-1:0]   nbits,
    input  logic [DATA_W-1:0] mosi_data,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              spi3w,
    output logic              ready,
    output logic [DATA_W-1:0] miso_data,
    output logic              miso_valid,
    output logic [NCS-1:0]    spi_csn,
    output logic              spi_sck,
    output logic              spi_mosi,
    output logic              spi_mosi_oe,
    input  logic              spi_miso,
    input  logic              spi_mosi_i
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [NB_W-1:0] TOP_BIT = NB_W'(DATA_W - 1);
    localparam logic [NB_W+1:0] TURN_V  = (NB_W + 2)'(TURN_BITS);

    state_t            state, state_nx;
    logic [DIV_W-1:0]  div_q, cnt_q;
    logic [NB_W-1:0]   nbits_q;
    logic [NB_W:0]     h_q, h_nx;
    logic [NB_W+1:0]   sh_done;
    logic [DATA_W-1:0] tx_q, rx_q;
    logic [CS_W-1:0]   cs_q;
    logic              cpol_q, cpha_q, w3_q, rd3_q;
    logic              tick, accept, start, last_half, edge_go, samp, shift, rx_bit;

    assign tick      = (cnt_q == div_q);
    assign accept    = request && (state == IDLE);
    assign start     = accept && (nbits != '0);
    assign last_half = (h_q == {nbits_q, 1'b1});
    // h_q counts SCK half-periods inside SHIFT; even halves are the active (leading) phase.
    assign edge_go   = tick && ((state == SETUP) || ((state == SHIFT) && !last_half));
    assign h_nx      = (state == SETUP) ? '0 : h_q + 1'b1;
    assign samp      = edge_go && (!h_nx[0] ^ cpha_q);
    assign shift     = edge_go && !samp && (h_nx != '0);
    assign sh_done   = cpha_q ? {2'b00, h_q[NB_W:1]} : (({1'b0, h_q} + 1'b1) >> 1);
    // In 3-wire mode our own driven bits are not data from the slave; they read back as 0.
    assign rx_bit    = w3_q ? (spi_mosi_i & ~spi_mosi_oe) : spi_miso;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SETUP;
            SETUP:   if (tick) state_nx = SHIFT;
            SHIFT:   if (tick && last_half) state_nx = HOLD;
            HOLD:    if (tick) state_nx = GAP;
            GAP:     if (tick) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            div_q      <= DIV_W'(DIV_COEF);
            cnt_q      <= '0;
            nbits_q    <= '0;
            h_q        <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            cs_q       <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            w3_q       <= 1'b0;
            rd3_q      <= 1'b0;
            miso_data  <= '0;
            miso_valid <= 1'b0;
        end else begin
            miso_valid <= 1'b0;
            if (accept && (nbits == '0)) begin
                div_q <= mosi_data[DIV_W-1:0];
            end
            if (start) begin
                nbits_q <= nbits;
                tx_q    <= mosi_data << (TOP_BIT - nbits);
                rx_q    <= '0;
                cs_q    <= cs_sel;
                cpol_q  <= cpol;
                cpha_q  <= cpha;
                w3_q    <= spi3w;
                rd3_q   <= spi3w && mosi_data[nbits] && ({2'b00, nbits} >= TURN_V);
                cnt_q   <= '0;
                h_q     <= '0;
            end else if (state != IDLE) begin
                cnt_q <= tick ? '0 : cnt_q + 1'b1;
            end
            if (edge_go) begin
                h_q <= h_nx;
            end
            if (samp) begin
                rx_q <= {rx_q[DATA_W-2:0], rx_bit};
            end
            if (shift) begin
                tx_q <= tx_q << 1;
            end
            if ((state == GAP) && tick) begin
                miso_valid <= 1'b1;
                miso_data  <= rx_q;
            end
        end
    end

    always_comb begin
        ready       = (state == IDLE);
        spi_sck     = (state == SHIFT) ? (cpol_q ^ ~h_q[0]) : cpol_q;
        spi_mosi    = ((state == SETUP) || (state == SHIFT)) ? tx_q[DATA_W-1] : 1'b0;
        spi_mosi_oe = !(rd3_q && (((state == SHIFT) && (sh_done >= TURN_V)) || (state == HOLD)));
        spi_csn     = '1;
        for (int i = 0; i < NCS; i++) begin
            if (((state == SETUP) || (state == SHIFT) || (state == HOLD)) && (cs_q == CS_W'(i))) begin
                spi_csn[i] = 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi: directed table, divider/reset sequences, and random transfers
// checked against a bit-level SPI slave and an arithmetic model of the expected results.
module tb_spi_master_multi;
    localparam int DW  = 32;
    localparam int NCS = 3;
    localparam int T   = 8;

    logic        clk_in = 1'b0, reset = 1'b1, request = 1'b0;
    logic [4:0]  nbits = '0;
    logic [31:0] mosi_data = '0;
    logic [1:0]  cs_sel = '0;
    logic        cpol = 1'b0, cpha = 1'b0, spi3w = 1'b0;
    logic        ready, miso_valid, spi_sck, spi_mosi, spi_mosi_oe, spi_miso, spi_mosi_i;
    logic [31:0] miso_data;
    logic [2:0]  spi_csn;

    spi_master_multi #(.DATA_W(DW), .NCS(NCS), .DIV_W(16), .DIV_COEF(1), .TURN_BITS(T)) dut (
        .clk_in(clk_in), .reset(reset), .request(request), .nbits(nbits), .mosi_data(mosi_data),
        .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha), .spi3w(spi3w), .ready(ready),
        .miso_data(miso_data), .miso_valid(miso_valid), .spi_csn(spi_csn), .spi_sck(spi_sck),
        .spi_mosi(spi_mosi), .spi_mosi_oe(spi_mosi_oe), .spi_miso(spi_miso), .spi_mosi_i(spi_mosi_i)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [4:0]  nb;
        logic [31:0] dat;
        logic [1:0]  cs;
        logic        cpol, cpha, w3;
        logic [31:0] sword;
        logic [31:0] exp_miso;
    } vec_t;

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Slave and bus observer state
    bit          mon_on = 0;
    logic        prev_sck, lead, m_cpol, m_cpha, m_rd3;
    int          pulses, per_err, oe_err, vcount, samp_cnt, sidx, last_lead, m_n;
    int          cyc = 0, cur_div = 1;
    logic [63:0] cap;
    logic [2:0]  csn_low;
    logic [31:0] s_word;
    logic        sbit;

    assign sbit       = (sidx < m_n) ? s_word[m_n-1-sidx] : 1'b0;
    assign spi_miso   = sbit;
    assign spi_mosi_i = spi_mosi_oe ? spi_mosi : sbit;

    always @(negedge clk_in) begin
        cyc = cyc + 1;
        if (mon_on) begin
            csn_low = csn_low | ~spi_csn;
            if (miso_valid) vcount++;
            if (spi_sck !== prev_sck) begin
                lead = (prev_sck == m_cpol);
                if (lead) begin
                    pulses++;
                    if (last_lead >= 0 && (cyc - last_lead) != 2 * (cur_div + 1)) per_err++;
                    last_lead = cyc;
                end
                if (lead ^ m_cpha) begin
                    cap = {cap[62:0], spi_mosi};
                    if (spi_mosi_oe !== !(m_rd3 && samp_cnt >= T)) oe_err++;
                    samp_cnt++;
                end else if (!m_cpha || pulses > 1) begin
                    sidx++;
                end
            end
            prev_sck = spi_sck;
        end
    end

    function automatic logic [63:0] mask(input int n);
        return (64'd1 << n) - 64'd1;
    endfunction

    // What the master should hand back, from the protocol rules alone
    function automatic logic [31:0] ref_miso(input vec_t v);
        int n = int'(v.nb) + 1;
        if (!v.w3) return 32'(v.sword & mask(n));
        if (v.dat[v.nb] && n > T) return 32'(v.sword & mask(n - T));
        return 32'd0;
    endfunction

    task automatic start_xfer(input vec_t v, input string nm);
        @(negedge clk_in); #1;
        pulses = 0; per_err = 0; oe_err = 0; vcount = 0; samp_cnt = 0; sidx = 0;
        last_lead = -1; cap = '0; csn_low = '0;
        m_cpol = v.cpol; m_cpha = v.cpha; m_n = int'(v.nb) + 1; s_word = v.sword;
        m_rd3 = v.w3 && v.dat[v.nb] && (m_n > T);
        request = 1'b1; nbits = v.nb; mosi_data = v.dat; cs_sel = v.cs;
        cpol = v.cpol; cpha = v.cpha; spi3w = v.w3;
        @(negedge clk_in); #1;
        request = 1'b0; mosi_data = $urandom; cpol = ~cpol; cpha = ~cpha; spi3w = ~spi3w;
        cs_sel = 2'($urandom);
        chk({nm, ".busy"}, ready, 0);
        chk({nm, ".sck_idle"}, spi_sck, v.cpol);
        prev_sck = spi_sck;
        mon_on = 1;
    endtask

    task automatic finish_xfer(input vec_t v, input logic [31:0] exp_miso, input string nm);
        bit got = 0;
        logic [31:0] data = '0;
        logic rdy = 0;
        int n = int'(v.nb) + 1;
        for (int i = 0; i < 6000 && !got; i++) begin
            @(negedge clk_in); #1;
            if (miso_valid) begin
                got = 1; data = miso_data; rdy = ready;
            end
        end
        @(negedge clk_in); #1;
        mon_on = 0;
        chk({nm, ".done"}, got, 1);
        chk({nm, ".miso"}, data, exp_miso);
        chk({nm, ".ready_at_valid"}, rdy, 1);
        chk({nm, ".mosi_bits"}, cap, {32'd0, v.dat} & mask(n));
        chk({nm, ".pulses"}, pulses, n);
        chk({nm, ".period"}, per_err, 0);
        chk({nm, ".oe"}, oe_err, 0);
        chk({nm, ".csn"}, csn_low, (v.cs < NCS) ? (3'b001 << v.cs) : 3'b000);
        chk({nm, ".valid_count"}, vcount, 1);
        chk({nm, ".idle_lines"}, {spi_mosi, spi_mosi_oe, spi_csn}, 5'b0_1_111);
    endtask

    task automatic load_div(input int d);
        @(negedge clk_in); #1;
        request = 1'b1; nbits = '0; mosi_data = 32'(d);
        @(negedge clk_in); #1;
        request = 1'b0;
        chk("divload.ready", ready, 1);
        chk("divload.csn", spi_csn, 3'b111);
        cur_div = d;
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, ".ready"}, ready, 1);
        chk({nm, ".csn"}, spi_csn, 3'b111);
        chk({nm, ".lines"}, {spi_sck, spi_mosi, spi_mosi_oe, miso_valid}, 4'b0010);
        chk({nm, ".miso_data"}, miso_data, 0);
    endtask

    vec_t vt[7];

    initial begin
        vec_t v;
        //        nb     dat            cs    cpol  cpha  w3    sword          exp_miso
        vt[0] = '{5'd15, 32'h0000_8f00, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0033, 32'h0000_0033};
        vt[1] = '{5'd7,  32'h0000_005A, 2'd2, 1'b1, 1'b1, 1'b0, 32'h0000_00C3, 32'h0000_00C3};
        vt[2] = '{5'd15, 32'h0000_8f00, 2'd1, 1'b0, 1'b0, 1'b1, 32'h0000_0033, 32'h0000_0033};
        vt[3] = '{5'd15, 32'h0000_0f00, 2'd0, 1'b0, 1'b1, 1'b1, 32'h0000_A5A5, 32'h0000_0000};
        vt[4] = '{5'd31, 32'hDEAD_BEEF, 2'd3, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h1234_5678};
        vt[5] = '{5'd8,  32'h0000_0100, 2'd0, 1'b1, 1'b0, 1'b1, 32'h0000_01AB, 32'h0000_0001};
        vt[6] = '{5'd7,  32'h0000_0080, 2'd2, 1'b0, 1'b1, 1'b1, 32'h0000_00FF, 32'h0000_0000};

        #1;
        check_reset_state("reset");
        @(negedge clk_in); reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            start_xfer(vt[i], $sformatf("vec%0d", i));
            finish_xfer(vt[i], vt[i].exp_miso, $sformatf("vec%0d", i));
        end

        load_div(3);
        v = '{5'd7, 32'h0000_00A5, 2'd1, 1'b0, 1'b0, 1'b0, 32'h0000_003C, 32'h0000_003C};
        start_xfer(v, "div3");
        finish_xfer(v, v.exp_miso, "div3");

        for (int i = 0; i < 20; i++) begin
            if (i % 5 == 0) load_div($urandom_range(0, 3));
            v.nb = 5'($urandom_range(1, 31));
            v.dat = $urandom; v.cs = 2'($urandom); v.cpol = 1'($urandom);
            v.cpha = 1'($urandom); v.w3 = 1'($urandom); v.sword = $urandom;
            v.exp_miso = ref_miso(v);
            start_xfer(v, $sformatf("rnd%0d", i));
            finish_xfer(v, v.exp_miso, $sformatf("rnd%0d", i));
        end

        // Abort mid-transfer: busy request must vanish, reset must leave no valid pulse
        v = '{5'd15, 32'h0000_8f00, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0033, 32'h0000_0033};
        start_xfer(v, "abort");
        for (int i = 0; i < 2000 && pulses < 5; i++) begin
            @(negedge clk_in); #1;
        end
        chk("abort.reached_pulse5", pulses, 5);
        request = 1'b1; nbits = 5'd7; mosi_data = 32'h0000_00FF; cs_sel = 2'd1;
        @(negedge clk_in); #1;
        request = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_reset_state("abort");
        @(negedge clk_in); #1;
        reset = 1'b0;
        cur_div = 1; csn_low = '0;
        begin
            int not_ready = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk_in); #1;
                if (!ready) not_ready++;
            end
            chk("abort.stays_ready", not_ready, 0);
        end
        chk("abort.no_csn", csn_low, 3'b000);
        chk("abort.no_valid", vcount, 0);
        mon_on = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
